// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into word-aligned memory
// transactions, owns the core stall handshake and times out hung accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic [1:0]  core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  localparam logic [1:0] FAULT_OK      = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic [31:0]       rd_q, rd_d;
  logic [1:0]        fault_q, fault_d;
  logic              stall;
  logic              size_legal;
  logic              misaligned;
  logic [CNT_W:0]    cnt_inc;
  logic              timeout_hit;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << {off[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // size[2] set selects zero extension (BU/HU)
  function automatic logic [31:0] load_extract(input logic [2:0] size, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size[1:0])
      2'b00:   r = size[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = size[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign size_legal  = core_size_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  assign misaligned  = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                       ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'b00));
  assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    off_d      = off_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    rd_d       = rd_q;
    fault_d    = FAULT_OK;
    stall      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          stall = 1'b1;
          if (!size_legal || misaligned) begin
            state_d = S_DONE;
            fault_d = FAULT_ALIGN;
          end else begin
            state_d    = S_BUSY;
            we_d       = core_we_i;
            size_d     = core_size_i;
            off_d      = core_addr_i[1:0];
            mem_req_d  = 1'b1;
            mem_we_d   = core_we_i;
            mem_be_d   = lane_mask(core_size_i, core_addr_i[1:0]);
            mem_addr_d = {core_addr_i[31:2], 2'b00};
            mem_wd_d   = lane_replicate(core_size_i, core_wd_i);
          end
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        // Memory outputs drop together when the access ends, for either cause.
        if (mem_ready_i || timeout_hit) begin
          state_d    = S_DONE;
          cnt_d      = '0;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = '0;
          mem_addr_d = '0;
          mem_wd_d   = '0;
          if (mem_ready_i) begin
            if (!we_q) rd_d = load_extract(size_q, off_q, mem_rd_i);
          end else begin
            fault_d = FAULT_TIMEOUT;
            rd_d    = '0;
          end
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_ni) stall = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      rd_q       <= '0;
      fault_q    <= FAULT_OK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      off_q      <= off_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      rd_q       <= rd_d;
      fault_q    <= fault_d;
    end
  end

  assign core_rd_o    = rd_q;
  assign core_stall_o = stall;
  assign core_fault_o = fault_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wd_o     = mem_wd_q;

endmodule
